// File: rtl/lynx_bus_pkg.sv
// Shared constants for the Lynx 48K bus glue: port numbers, register bit
// positions and the interrupt FSM state encoding.
package lynx_bus_pkg;

    // Address map and I/O ports
    localparam logic [15:0] ROM_TOP_DEF   = 16'h6000;
    localparam int          INT_LEN_DEF   = 32;
    localparam logic [7:0]  PORT_BANK_DEF = 8'h80;
    localparam logic [7:0]  PORT_VID_DEF  = 8'h82;

    // Bit positions inside the video control register
    localparam int INT_EN  = 6;

    // Bit positions inside the bank register
    localparam int ROM_OFF = 0;   // 1: reads below ROM_TOP come from RAM
    localparam int WR_THRU = 1;   // 1: writes below ROM_TOP reach RAM

    // Frame interrupt pulse generator states
    typedef enum logic {
        INT_IDLE   = 1'b0,
        INT_ACTIVE = 1'b1
    } int_state_t;

endpackage

// File: rtl/lynx_bus_ctrl_cycle_strobe.sv
// One-shot write strobe: fires for a single clock on the first cep clock on
// which a write cycle (req_n=0, wr_n=0) is seen, then stays quiet until the
// request has been observed high again on a cep clock.
module cycle_strobe (
    input  logic clock,
    input  logic reset,
    input  logic req_n,
    input  logic wr_n,
    input  logic cep,
    output logic stb
);

    logic r_armed;
    logic r_stb;

    // Arm while the request is idle; fire once and disarm on a write cycle
    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b1;
            r_stb   <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            if (cep) begin
                if (req_n) begin
                    r_armed <= 1'b1;
                end else if (!wr_n && r_armed) begin
                    r_armed <= 1'b0;
                    r_stb   <= 1'b1;
                end
            end
        end
    end

    assign stb = r_stb;

endmodule

// File: rtl/lynx_bus_ctrl.sv
// Glue between the Z80 wrapper and Lynx 48K memory/I/O: write strobes, bank
// and video control registers, CPU read mux and the vsync frame interrupt.
module lynx_bus_ctrl
    import lynx_bus_pkg::*;
#(
    parameter logic [15:0] ROM_TOP   = ROM_TOP_DEF,
    parameter int          INT_LEN   = INT_LEN_DEF,
    parameter logic [7:0]  PORT_BANK = PORT_BANK_DEF,
    parameter logic [7:0]  PORT_VID  = PORT_VID_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cep,
    input  logic        mreq,
    input  logic        iorq,
    input  logic        wr,
    input  logic [15:0] a,
    input  logic [7:0]  cpu_do,
    output logic [7:0]  cpu_di,
    input  logic [7:0]  rom_do,
    input  logic [7:0]  ram_do,
    input  logic [7:0]  key_do,
    output logic [3:0]  key_row,
    output logic        ram_we,
    output logic [7:0]  bank,
    output logic [7:0]  vid,
    input  logic        vsync,
    output logic        int_n
);

    localparam logic [7:0] CNT_LOAD = 8'(INT_LEN - 1);

    logic       w_mem_stb;
    logic       w_io_stb;
    logic       w_below_rom;
    logic       w_vs_edge;
    logic [7:0] w_cpu_di;

    logic [7:0] r_bank;
    logic [7:0] r_vid;
    logic [1:0] r_vs_sync;
    logic       r_vs_prev;
    int_state_t r_int_state;
    logic [7:0] r_cnt;
    logic       r_int_n;

    cycle_strobe u_mem_stb (
        .clock (clock),
        .reset (reset),
        .req_n (mreq),
        .wr_n  (wr),
        .cep   (cep),
        .stb   (w_mem_stb)
    );

    cycle_strobe u_io_stb (
        .clock (clock),
        .reset (reset),
        .req_n (iorq),
        .wr_n  (wr),
        .cep   (cep),
        .stb   (w_io_stb)
    );

    assign w_below_rom = (a < ROM_TOP);

    // RAM is written above ROM, or under ROM when write-through is enabled
    assign ram_we  = w_mem_stb & (~w_below_rom | r_bank[WR_THRU]);
    assign key_row = a[11:8];

    // Capture bank/video port writes; the high address byte is ignored
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bank <= 8'h00;
            r_vid  <= 8'h00;
        end else if (w_io_stb) begin
            if (a[7:0] == PORT_BANK) begin
                r_bank <= cpu_do;
            end else if (a[7:0] == PORT_VID) begin
                r_vid <= cpu_do;
            end
        end
    end

    // CPU read mux; an I/O request takes priority over a memory request
    // NOTE: the default assignment first keeps every path covered, so no latch.
    always_comb begin
        w_cpu_di = 8'hFF;
        if (!iorq) begin
            if (a[7:0] == PORT_BANK) begin
                w_cpu_di = key_do;
            end
        end else if (!mreq) begin
            if (w_below_rom && !r_bank[ROM_OFF]) begin
                w_cpu_di = rom_do;
            end else begin
                w_cpu_di = ram_do;
            end
        end
    end

    assign cpu_di = w_cpu_di;

    // Bring vsync into the clock domain and remember its last value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vs_sync <= 2'b00;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_sync <= {r_vs_sync[0], vsync};
            r_vs_prev <= r_vs_sync[1];
        end
    end

    assign w_vs_edge = r_vs_sync[1] & ~r_vs_prev;

    // Frame interrupt: INT_LEN cep ticks low per enabled vsync edge, retriggerable
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_int_state <= INT_IDLE;
            r_cnt       <= 8'h00;
            r_int_n     <= 1'b1;
        end else begin
            case (r_int_state)
                INT_IDLE: begin
                    if (w_vs_edge && r_vid[INT_EN]) begin
                        r_int_state <= INT_ACTIVE;
                        r_cnt       <= CNT_LOAD;
                        r_int_n     <= 1'b0;
                    end
                end
                INT_ACTIVE: begin
                    // A fresh edge restarts the pulse regardless of the enable bit
                    if (w_vs_edge) begin
                        r_cnt <= CNT_LOAD;
                    end else if (cep) begin
                        if (r_cnt == 8'h00) begin
                            r_int_state <= INT_IDLE;
                            r_int_n     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 8'h01;
                        end
                    end
                end
                default: begin
                    r_int_state <= INT_IDLE;
                    r_int_n     <= 1'b1;
                end
            endcase
        end
    end

    assign bank  = r_bank;
    assign vid   = r_vid;
    assign int_n = r_int_n;

endmodule
